// File: rtl/rf_debug_reader_pkg.sv
// Shared definitions for the register-file debug walker: default sizing,
// FSM state encoding and the field layout of the 8-digit display word.
package rf_debug_reader_pkg;

  localparam int NREG_DEF     = 32;
  localparam int AW_DEF       = 5;
  localparam int STEP_DIV_DEF = 25_000_000;
  localparam int DATA_W       = 32;

  // disp_word layout: {zero pad, register index, low 24 bits of the value}
  localparam int DW_W       = 32;
  localparam int DW_IDX_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_CAPT = 2'd2,
    ST_SHOW = 2'd3
  } state_e;

endpackage

// File: rtl/rf_debug_reader_step_timer.sv
// Clear/enable/terminal-count counter. Counts 0..DIV-1 while enabled and
// wraps to 0 after the terminal value; clear has priority over enable.
module step_timer #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_o = (count_q == LAST);

  // next count: clear wins, otherwise count up and wrap at the terminal value
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rf_debug_reader.sv
// Read-side debug walker for the register file. Steps an index through
// x0..x(NREG-1), reads each register through the RF second read port and
// presents {index, value} to the 7-segment driver.
//
// Output handshake: disp_valid is a single-cycle qualifier with no
// back-pressure. disp_idx/disp_data/disp_word change only on the cycle
// disp_valid is high and stay stable until the next pulse; a consumer that
// wants every word must take it on the pulse cycle.
module rf_debug_reader
  import rf_debug_reader_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int AW       = AW_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              auto,
  input  logic              hold,
  input  logic              step_req,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [AW-1:0]     disp_idx,
  output logic [DATA_W-1:0] disp_data,
  output logic [DW_W-1:0]   disp_word,
  output logic              disp_valid,
  output logic              busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     disp_idx_q, disp_idx_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;

  logic              timer_clr;
  logic              timer_en;
  logic              timer_tc;
  logic              advance;
  logic [AW-1:0]     next_idx;

  // Advance timer: only runs in SHOW with auto on and hold off; cleared on
  // every advance and whenever the walk is disabled.
  step_timer #(
    .DIV (STEP_DIV)
  ) u_step_timer (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  // index arithmetic is modulo NREG
  assign next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + AW'(1);

  // FSM next-state, index stepping, capture and timer control
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    disp_idx_d   = disp_idx_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    advance      = 1'b0;
    if (!en) begin
      // leaving debug mode: back to IDLE, display keeps its last word
      state_d   = ST_IDLE;
      idx_d     = '0;
      timer_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_ADDR;
          idx_d     = '0;
          timer_clr = 1'b1;
        end
        ST_ADDR: begin
          // rd_addr already holds the index; RF data settles this cycle
          state_d = ST_CAPT;
        end
        ST_CAPT: begin
          disp_data_d  = rd_data;
          disp_idx_d   = idx_q;
          disp_valid_d = 1'b1;
          state_d      = ST_SHOW;
        end
        ST_SHOW: begin
          timer_en = auto && !hold;
          // timer expiry and a button press in the same cycle merge into one step
          advance  = (timer_en && timer_tc) || (step_req && !hold);
          if (advance) begin
            timer_clr = 1'b1;
            idx_d     = next_idx;
            state_d   = ST_ADDR;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // state, index and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      disp_idx_q   <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      disp_idx_q   <= disp_idx_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  // The index register drives the RF read port directly, so rd_addr is
  // registered and reads 0 in IDLE.
  assign rd_addr    = idx_q;
  assign disp_idx   = disp_idx_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign disp_word  = {{(DW_W - DW_IDX_LSB - AW){1'b0}}, disp_idx_q,
                       disp_data_q[DW_IDX_LSB-1:0]};

endmodule

// File: doc/rf_debug_reader.md
Name: rf_debug_reader

Overview:
- Read-side debug walker for the register file, active when the board is in debug mode (sw_i[1] high).
- Steps a read address through x0..x(NREG-1) and drives the RF's second read port while writes are suppressed.
- Captures each returned word and presents {index, value} to the 7-segment display driver with a one-cycle valid pulse.
- Advances either on an internal timer (auto) or on a debounced button pulse (manual).

Parameters:
- NREG, 32, number of registers walked; index wraps at NREG-1.
- AW, 5, register index width; clog2(NREG).
- STEP_DIV, 25_000_000, clk cycles per auto step (0.25 s at 100 MHz); minimum 4.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous active-high reset.
- en  in  1  debug enable (sw_i[1]); low forces IDLE.
- auto  in  1  1 = timer-driven advance, 0 = manual only.
- hold  in  1  freezes timer and index while high; display keeps current value.
- step_req  in  1  single-cycle advance pulse, already debounced.
- rd_addr  out  AW  register index driven to the RF read port.
- rd_data  in  32  RF read data; combinational from rd_addr.
- disp_idx  out  AW  index of the displayed register.
- disp_data  out  32  captured register value.
- disp_word  out  32  {3'b0, disp_idx, disp_data[23:0]}, formatted for the 8-digit display.
- disp_valid  out  1  one-cycle pulse when disp_* update.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset and IDLE
- Reset (async assert, sync release): state IDLE; rd_addr, disp_idx, disp_data, disp_word, disp_valid, busy, timer all 0.
- IDLE: rd_addr=0, busy=0. When en=1, go to ADDR next cycle with index 0.

States
- ADDR: rd_addr=index (registered); go to CAPT.
- CAPT: sample rd_data into disp_data and index into disp_idx; go to SHOW.
- disp_valid=1 on the first SHOW cycle only.
- SHOW: the timer counts while auto=1 and hold=0. Advance when timer==STEP_DIV-1, or on step_req=1 with hold=0.
- On advance: timer clears, index increments (NREG-1 wraps to 0), go to ADDR.

Latency and width rules
- en rise to first disp_valid: 3 cycles.
- Advance to next disp_valid: 3 cycles.
- Auto-mode period: STEP_DIV+2 cycles between valid pulses.
- Index 0 shows 0 regardless of RF contents, because the RF returns 0 for x0.
- disp_word upper bits are zero-extended. Index arithmetic is modulo NREG; no overflow flag.

Boundary conditions
- step_req and timer expiry in the same cycle: a single advance.
- step_req outside SHOW: ignored, not queued.
- hold=1: step_req ignored; timer holds its value and resumes from it.
- auto toggled mid-count: timer keeps its value and resumes when auto returns to 1.
- en falls in any state: next cycle IDLE, index 0, timer 0. disp_idx and disp_data retain their last value, and no valid pulse is issued.
- en re-asserted: the walk restarts at x0.
- rst mid-walk: immediate return to reset values.
- The RF must not be written while en=1. This block does not gate RFWr; the top level guarantees it.

Decomposition:
- Shared package: AW, NREG, state encoding (IDLE, ADDR, CAPT, SHOW as 2-bit enum), disp_word field positions.
- One sub-module: step_timer (clear/enable/terminal-count counter, width clog2(STEP_DIV)), reused by the display scan logic.
- The FSM and capture registers stay in rf_debug_reader.

Test Plan:
- Reset then en=1, auto=0, RF model rf[i]=i*16 -> after 3 cycles disp_valid pulse, disp_idx=0, disp_data=0, disp_word=0x00000000.
- Manual mode, 32 step_req pulses spaced 10 cycles apart -> disp_idx sequence 1..31 then 0; e.g. idx 5 gives disp_data=0x50 and disp_word=0x05000050.
- auto=1, STEP_DIV=8 -> disp_valid every 10 cycles; hold=1 for 20 cycles mid-count stops pulses, and the remaining count resumes after release.
- step_req in the same cycle as terminal count, STEP_DIV=4 -> exactly one index increment and one disp_valid.
- en dropped during ADDR at index 7 -> busy=0 and rd_addr=0 next cycle, no disp_valid. Re-enabling gives a first display at index 0.
- rst asserted in SHOW at index 12 -> all outputs 0 asynchronously; after release with en=1, the walk restarts at x0.
